// File: rtl/power_load_ramp_ctrl.sv
// Thermometer-coded load sequencer for the power-consumer bank array.
// Steps load up/down once per dwell period to bound di/dt on VCCINT.
module power_load_ramp_ctrl #(
  parameter int NUM_BANKS    = 16,
  parameter int STEP         = 1,
  parameter int DWELL_CYCLES = 100000000,
  parameter int LVL_W        = $clog2(NUM_BANKS + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 abort,
  input  logic                 repeat_en,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic [LVL_W-1:0]     level,
  output logic                 busy,
  output logic [15:0]          cycle_count,
  output logic [3:0]           USER_LED
);

  localparam int CNT_W =
    (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [LVL_W-1:0] TOP = LVL_W'(NUM_BANKS);
  localparam logic [LVL_W-1:0] STP = LVL_W'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    HOLD_TOP,
    RAMP_DOWN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hb;
  logic             expiry;

  assign expiry = (cnt == CNT_MAX);

  function automatic logic [LVL_W-1:0] lvl_up(
    input logic [LVL_W-1:0] l
  );
    logic [LVL_W:0] s;
    s = {1'b0, l} + {1'b0, STP};
    return (s >= {1'b0, TOP}) ? TOP : s[LVL_W-1:0];
  endfunction

  function automatic logic [LVL_W-1:0] lvl_dn(
    input logic [LVL_W-1:0] l
  );
    return (l > STP) ? (l - STP) : '0;
  endfunction

  function automatic logic [NUM_BANKS-1:0] thermo(
    input logic [LVL_W-1:0] l
  );
    logic [NUM_BANKS-1:0] t;
    for (int i = 0; i < NUM_BANKS; i++)
      t[i] = (i < int'(l));
    return t;
  endfunction

  // First step from zero may already reach the top when STEP == NUM_BANKS.
  function automatic state_t first_state();
    return (lvl_up('0) == TOP) ? HOLD_TOP : RAMP_UP;
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= IDLE;
      level       <= '0;
      bank_en     <= '0;
      cnt         <= '0;
      hb          <= 1'b0;
      cycle_count <= '0;
    end else if (abort) begin
      state   <= IDLE;
      level   <= '0;
      bank_en <= '0;
      cnt     <= '0;
      hb      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state   <= first_state();
            level   <= lvl_up('0);
            bank_en <= thermo(lvl_up('0));
            cnt     <= '0;
          end
        end
        RAMP_UP: begin
          if (stop) begin
            state <= RAMP_DOWN;
            cnt   <= '0;
          end else if (expiry) begin
            cnt     <= '0;
            hb      <= ~hb;
            level   <= lvl_up(level);
            bank_en <= thermo(lvl_up(level));
            if (lvl_up(level) == TOP)
              state <= HOLD_TOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HOLD_TOP: begin
          if (stop) begin
            state <= RAMP_DOWN;
            cnt   <= '0;
          end else if (expiry) begin
            cnt <= '0;
            hb  <= ~hb;
            if (repeat_en)
              state <= RAMP_DOWN;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RAMP_DOWN: begin
          if (expiry) begin
            cnt <= '0;
            hb  <= ~hb;
            if (lvl_dn(level) == '0) begin
              if (cycle_count != 16'hFFFF)
                cycle_count <= cycle_count + 16'd1;
              if (repeat_en && !stop) begin
                state   <= first_state();
                level   <= lvl_up('0);
                bank_en <= thermo(lvl_up('0));
              end else begin
                state   <= IDLE;
                level   <= '0;
                bank_en <= '0;
              end
            end else begin
              level   <= lvl_dn(level);
              bank_en <= thermo(lvl_dn(level));
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign USER_LED = {state == RAMP_DOWN, level == TOP, busy, hb};

endmodule

// File: tb/tb_power_load_ramp_ctrl.sv
// Directed bench for power_load_ramp_ctrl: table vectors plus
// hand sequences for triangle, stop, abort and STEP=3 saturation.
module tb_power_load_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, abort, rep;
  logic [3:0]  be_a, be_b;
  logic [2:0]  lv_a, lv_b;
  logic        busy_a, busy_b;
  logic [15:0] cc_a, cc_b;
  logic [3:0]  led_a, led_b;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  power_load_ramp_ctrl #(
    .NUM_BANKS(4), .STEP(1), .DWELL_CYCLES(3)
  ) dut_a (
    .clk_in(clk), .rst(rst), .start(start), .stop(stop),
    .abort(abort), .repeat_en(rep), .bank_en(be_a),
    .level(lv_a), .busy(busy_a), .cycle_count(cc_a),
    .USER_LED(led_a)
  );

  power_load_ramp_ctrl #(
    .NUM_BANKS(4), .STEP(3), .DWELL_CYCLES(3)
  ) dut_b (
    .clk_in(clk), .rst(rst), .start(start), .stop(stop),
    .abort(abort), .repeat_en(rep), .bank_en(be_b),
    .level(lv_b), .busy(busy_b), .cycle_count(cc_b),
    .USER_LED(led_b)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic       stop;
    logic       abort;
    logic       rep;
    int         lvl;
    logic [3:0] led;
    int         cc;
  } vec_t;

  vec_t tbl[24];

  localparam logic [3:0] ALL = 4'b1111;
  localparam logic [3:0] NHB = 4'b1110;

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) edge_();
  endtask

  task automatic chk(input string nm, input bit b, input int lvl,
                     input logic [3:0] led, input logic [3:0] mask,
                     input int cc);
    logic [3:0]  a_be, e_be, a_led;
    logic [2:0]  a_lv;
    logic        a_bs;
    logic [15:0] a_cc;
    a_be  = b ? be_b : be_a;
    a_lv  = b ? lv_b : lv_a;
    a_bs  = b ? busy_b : busy_a;
    a_cc  = b ? cc_b : cc_a;
    a_led = b ? led_b : led_a;
    e_be  = 4'((1 << lvl) - 1);
    nvec++;
    if (int'(a_lv) != lvl || a_be != e_be || a_bs != led[1] ||
        (a_led & mask) != (led & mask) || int'(a_cc) != cc) begin
      nbad++;
      $display({"FAIL %s: got lvl=%0d be=%b busy=%b led=%b cc=%0d",
                " want lvl=%0d be=%b busy=%b led=%b(mask %b) cc=%0d"},
               nm, a_lv, a_be, a_bs, a_led, a_cc,
               lvl, e_be, led[1], led, mask, cc);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; abort = 1'b0; rep = 1'b0;

    //          rst start stop abort rep  lvl led     cc
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 4'b0000, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 4'b0010, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 4'b0010, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 4'b0010, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 4'b0011, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 4'b0011, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 4'b0011, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 4'b0010, 0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 4'b0010, 0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 4'b0010, 0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0111, 0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0111, 0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0111, 0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0110, 0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0110, 0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0110, 0};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0111, 0};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 0};

    #1;
    for (int i = 0; i < 24; i++) begin
      rst   = tbl[i].rst;
      start = tbl[i].start;
      stop  = tbl[i].stop;
      abort = tbl[i].abort;
      rep   = tbl[i].rep;
      edge_();
      chk($sformatf("vec%0d", i), 1'b0, tbl[i].lvl,
          tbl[i].led, ALL, tbl[i].cc);
    end
    abort = 1'b0;

    // Continuous triangle: 1..4, hold, 3..1, wrap to 1 with cc=1
    rep = 1'b1; start = 1'b1;
    edge_();
    start = 1'b0;
    chk("tri_l1", 1'b0, 1, 4'b0010, NHB, 0);
    for (int l = 2; l <= 4; l++) begin
      run(3);
      chk($sformatf("tri_up%0d", l), 1'b0, l,
          (l == 4) ? 4'b0110 : 4'b0010, NHB, 0);
    end
    run(2);
    chk("tri_hold", 1'b0, 4, 4'b0110, NHB, 0);
    run(1);
    chk("tri_dn_enter", 1'b0, 4, 4'b1110, NHB, 0);
    for (int l = 3; l >= 1; l--) begin
      run(3);
      chk($sformatf("tri_dn%0d", l), 1'b0, l, 4'b1010, NHB, 0);
    end
    run(3);
    chk("tri_wrap", 1'b0, 1, 4'b0010, NHB, 1);

    // Stop at level 2 while ramping up
    run(3);
    chk("stop_pre", 1'b0, 2, 4'b0010, NHB, 1);
    stop = 1'b1;
    edge_();
    chk("stop_dn", 1'b0, 2, 4'b1010, NHB, 1);
    run(3);
    chk("stop_l1", 1'b0, 1, 4'b1010, NHB, 1);
    run(3);
    chk("stop_idle", 1'b0, 0, 4'b0000, NHB, 2);
    stop = 1'b0;
    run(2);
    chk("stop_stay", 1'b0, 0, 4'b0000, NHB, 2);

    // Abort at level 3, together with stop and start
    start = 1'b1;
    edge_();
    start = 1'b0;
    run(6);
    chk("abort_pre", 1'b0, 3, 4'b0010, NHB, 2);
    abort = 1'b1; stop = 1'b1; start = 1'b1;
    edge_();
    chk("abort_all", 1'b0, 0, 4'b0000, ALL, 2);
    abort = 1'b0; stop = 1'b0; start = 1'b0;
    edge_();
    chk("abort_idle", 1'b0, 0, 4'b0000, ALL, 2);

    // Reset mid-ramp clears everything including cycle_count
    start = 1'b1;
    edge_();
    start = 1'b0;
    run(4);
    chk("rst_pre", 1'b0, 2, 4'b0010, NHB, 2);
    rst = 1'b1;
    edge_();
    rst = 1'b0;
    chk("rst_mid", 1'b0, 0, 4'b0000, ALL, 0);

    // STEP=3 instance: saturate at 4, floor at 0
    rep = 1'b1; start = 1'b1;
    edge_();
    start = 1'b0;
    chk("s3_l3", 1'b1, 3, 4'b0010, NHB, 0);
    run(3);
    chk("s3_top", 1'b1, 4, 4'b0110, NHB, 0);
    run(3);
    chk("s3_dn", 1'b1, 4, 4'b1110, NHB, 0);
    run(3);
    chk("s3_l1", 1'b1, 1, 4'b1010, NHB, 0);
    rep = 1'b0;
    run(3);
    chk("s3_floor", 1'b1, 0, 4'b0000, NHB, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/power_load_ramp_ctrl.md
Name: power_load_ramp_ctrl

Overview:
- Sequencer that sits directly upstream of the top_log power-consumer array.
- Drives a thermometer-coded bank-enable vector so load is stepped up and down in timed increments, never switched in one step, to avoid large di/dt events on VCCINT during power measurement.
- Clocked from the 100 MHz CIPS PL clock.
- Exports a 4-bit status nibble suitable for USER_LED.

Parameters:
- NUM_BANKS, 16, number of independently enabled consumer banks; legal range 1..64.
- STEP, 1, banks added or removed per dwell period; legal range 1..NUM_BANKS.
- DWELL_CYCLES, 100000000, clocks per dwell period (1 s at 100 MHz); minimum 1.
- LVL_W, $clog2(NUM_BANKS+1), width of the level count (derived; do not override).

Ports:
- clk_in, input, 1, single clock for all logic.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, level-sampled; begins a ramp from IDLE.
- stop, input, 1, level-sampled; graceful ramp-down request.
- abort, input, 1, level-sampled; immediate load removal.
- repeat_en, input, 1, 1 = continuous triangle ramp, 0 = single ramp up then hold.
- bank_en, output, NUM_BANKS, registered thermometer enable; bit i = (i < level).
- level, output, LVL_W, registered count of enabled banks.
- busy, output, 1, high whenever state != IDLE.
- cycle_count, output, 16, completed triangle cycles; saturates at 0xFFFF.
- USER_LED, output, 4, status: [0] heartbeat, [1] busy, [2] at_top (level==NUM_BANKS), [3] ramping down.

Behaviour:
- Reset (rst=1 at a clk_in edge): state=IDLE; level=0; bank_en=0; dwell counter=0; cycle_count=0; heartbeat=0. Therefore USER_LED=0 and busy=0.
- All outputs are registered. bank_en and level always update on the same edge, so bank_en always equals the thermometer code of level.
- Dwell counter:
  - Counts 0..DWELL_CYCLES-1 in RAMP_UP, HOLD_TOP and RAMP_DOWN.
  - "Expiry" = counter==DWELL_CYCLES-1. On expiry the counter returns to 0 and the heartbeat toggles.
  - The counter is cleared on every state change.
- Input priority each cycle: abort > stop > start.
- IDLE:
  - start=1 → RAMP_UP, level=STEP.
  - stop alone is ignored.
- RAMP_UP, on expiry:
  - level = min(level+STEP, NUM_BANKS).
  - If the new level == NUM_BANKS → HOLD_TOP.
  - If STEP == NUM_BANKS, the first start goes straight to HOLD_TOP with level=NUM_BANKS.
- HOLD_TOP, on expiry:
  - repeat_en=1 → RAMP_DOWN.
  - repeat_en=0 → stay in HOLD_TOP, level unchanged.
- RAMP_DOWN, on expiry:
  - level = max(level-STEP, 0).
  - When the new level == 0: cycle_count increments (saturating). Then repeat_en=1 and stop=0 → RAMP_UP with level=STEP; otherwise → IDLE.
- stop=1 in RAMP_UP or HOLD_TOP:
  - Next state is RAMP_DOWN; counter cleared; level unchanged on that edge.
  - In RAMP_DOWN, stop suppresses the repeat so the block ends in IDLE.
  - A return to 0 caused by stop still counts as a cycle only if the preceding state was HOLD_TOP or later in the triangle. Simplification adopted: cycle_count increments on every RAMP_DOWN→0 transition regardless.
- abort=1 in any state: next edge state=IDLE, level=0, bank_en=0, counter=0, heartbeat=0. cycle_count is unchanged.
- start held high continuously in IDLE restarts the ramp on the next edge. No edge detection is performed.
- USER_LED[3]=1 exactly when state==RAMP_DOWN. USER_LED[2] follows level==NUM_BANKS.
- rst asserted mid-ramp: identical to the reset values above on that edge. No ramp-down is performed.
- No combinational path from any input to any output.

Test Plan:
(Bench parameters: NUM_BANKS=4, STEP=1, DWELL_CYCLES=3.)
- rst for 2 cycles, then idle 10 cycles → bank_en=0, level=0, USER_LED=0, busy=0 throughout; stop pulse in IDLE has no effect.
- start 1 cycle, repeat_en=0 → bank_en=0001 one edge after start. Then 0011, 0111, 1111 at 3-cycle spacing. USER_LED[2]=1 at level 4; block holds 1111 indefinitely; heartbeat toggles every 3 cycles.
- repeat_en=1, start → levels 1,2,3,4, hold 3 cycles, then 3,2,1,0 → cycle_count=1 → immediately level=1 again (RAMP_UP).
- During repeat, stop asserted at level 2 in RAMP_UP → RAMP_DOWN with USER_LED[3]=1. Levels 1 then 0, each after 3 cycles; ends in IDLE, busy=0, cycle_count incremented.
- abort at level 3 → next edge bank_en=0000, busy=0, USER_LED=0. Simultaneous abort+stop+start → abort wins.
- Re-parameterise STEP=3, NUM_BANKS=4 → levels 3 then 4 (saturated), HOLD_TOP. On ramp-down: 1 then 0 (floored).
